// File: rtl/sdram_port_arb.sv
// Two-client whole-burst arbiter in front of sdram_ctrl: grants one port, counts acks, routes data.
// Optional SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin.
module sdram_port_arb #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [LEN_W-1:0]  c0_len,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_wr_ack,
    output logic              c0_rd_ack,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_done,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [LEN_W-1:0]  c1_len,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_wr_ack,
    output logic              c1_rd_ack,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_done,
    output logic              ctl_wr_req,
    output logic              ctl_rd_req,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [LEN_W-1:0]  ctl_len,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_wr_ack,
    input  logic              ctl_rd_ack,
    input  logic [DATA_W-1:0] ctl_rdata
);

    // 9 bits covers ack counts 0..255 for the longest legal burst of 256
    localparam int unsigned CNT_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e              state_q,   state_d;
    logic [1:0]          gnt_q,     gnt_d;
    logic                dir_we_q,  dir_we_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [LEN_W-1:0]    len_q,     len_d;
    logic                wr_req_q,  wr_req_d;
    logic                rd_req_q,  rd_req_d;
    logic [1:0]          done_q,    done_d;
    logic [CNT_W-1:0]    ack_cnt_q, ack_cnt_d;

    logic                win1;
    logic                ack_hit;
    logic                in_burst;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign win1 = ~c0_req;
`else
    logic rr_last_q, rr_last_d;

    // On a tie the port that was not served last wins
    assign win1 = c1_req & (~c0_req | ~rr_last_q);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (state_q == ST_DONE) begin
            rr_last_d = gnt_q[1];
        end
    end
`endif

    assign ack_hit  = dir_we_q ? ctl_wr_ack : ctl_rd_ack;
    assign in_burst = (state_q == ST_BURST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            dir_we_q  <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            done_q    <= 2'b00;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            dir_we_q  <= dir_we_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            done_q    <= done_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        dir_we_d  = dir_we_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        done_d    = 2'b00;
        ack_cnt_d = ack_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (init_end && (c0_req || c1_req)) begin
                    gnt_d     = win1 ? 2'b10 : 2'b01;
                    dir_we_d  = win1 ? c1_we : c0_we;
                    addr_d    = win1 ? c1_addr : c0_addr;
                    len_d     = win1 ? c1_len : c0_len;
                    // A zero-length burst is granted but never reaches the controller
                    wr_req_d  = dir_we_d && (len_d != '0);
                    rd_req_d  = !dir_we_d && (len_d != '0);
                    ack_cnt_d = '0;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (len_q == '0) begin
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (ack_hit) begin
                    if (LEN_W'(ack_cnt_q) == len_q - LEN_W'(1)) begin
                        wr_req_d  = 1'b0;
                        rd_req_d  = 1'b0;
                        ack_cnt_d = '0;
                        done_d    = gnt_q;
                        state_d   = ST_DONE;
                    end else begin
                        ack_cnt_d = ack_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d    = 2'b00;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Datapath routing to and from the granted port
    assign c0_gnt     = gnt_q[0];
    assign c1_gnt     = gnt_q[1];
    assign c0_done    = done_q[0];
    assign c1_done    = done_q[1];
    assign ctl_wr_req = wr_req_q;
    assign ctl_rd_req = rd_req_q;
    assign c0_wr_ack  = ctl_wr_ack & gnt_q[0] & dir_we_q & in_burst;
    assign c1_wr_ack  = ctl_wr_ack & gnt_q[1] & dir_we_q & in_burst;
    assign c0_rd_ack  = ctl_rd_ack & gnt_q[0] & ~dir_we_q & in_burst;
    assign c1_rd_ack  = ctl_rd_ack & gnt_q[1] & ~dir_we_q & in_burst;
    assign c0_rdata   = ctl_rdata;
    assign c1_rdata   = ctl_rdata;
    assign ctl_addr   = in_burst ? addr_q : '0;
    assign ctl_len    = in_burst ? len_q : '0;
    assign ctl_wdata  = gnt_q[0] ? c0_wdata : (gnt_q[1] ? c1_wdata : '0);

endmodule

// File: tb/tb_sdram_port_arb.sv
// Randomized self-checking bench for sdram_port_arb against a grant-order / ack-count model.
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [23:0] c0_addr, c1_addr;
    logic [9:0]  c0_len, c1_len;
    logic [15:0] c0_wdata, c1_wdata;
    logic        c0_gnt, c0_wr_ack, c0_rd_ack, c0_done;
    logic        c1_gnt, c1_wr_ack, c1_rd_ack, c1_done;
    logic [15:0] c0_rdata, c1_rdata;
    logic        ctl_wr_req, ctl_rd_req;
    logic [23:0] ctl_addr;
    logic [9:0]  ctl_len;
    logic [15:0] ctl_wdata;
    logic        ctl_wr_ack, ctl_rd_ack;
    logic [15:0] ctl_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    sdram_port_arb dut (
        .sys_clk(clk), .sys_rst(rst), .init_end(init_end),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_len(c0_len),
        .c0_wdata(c0_wdata), .c0_gnt(c0_gnt), .c0_wr_ack(c0_wr_ack),
        .c0_rd_ack(c0_rd_ack), .c0_rdata(c0_rdata), .c0_done(c0_done),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_len(c1_len),
        .c1_wdata(c1_wdata), .c1_gnt(c1_gnt), .c1_wr_ack(c1_wr_ack),
        .c1_rd_ack(c1_rd_ack), .c1_rdata(c1_rdata), .c1_done(c1_done),
        .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req), .ctl_addr(ctl_addr),
        .ctl_len(ctl_len), .ctl_wdata(ctl_wdata), .ctl_wr_ack(ctl_wr_ack),
        .ctl_rd_ack(ctl_rd_ack), .ctl_rdata(ctl_rdata)
    );

    // Reference arbitration rule: the lone requester, else the port not served last
    function automatic int model_pick(input bit r0, input bit r1, input int last);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return 1 - last;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        c0_req = 0; c1_req = 0; ctl_wr_ack = 0; ctl_rd_ack = 0;
        tick(); tick();
        rst = 1'b0;
        model_last = 1;
        tick();
    endtask

    task automatic wait_grant(output int port, output bit timed_out);
        port = -1;
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (c0_gnt || c1_gnt) begin
                port = c1_gnt ? 1 : 0;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Feeds len controller acks to the granted port and records what the DUT did
    task automatic serve_burst(input int p, input bit we, input int len, input bit stray,
                               output int n_fwd, output int n_bad, output int n_done,
                               output bit req_ok);
        n_fwd = 0; n_bad = 0; n_done = 0; req_ok = 1'b1;
        for (int i = 0; i < len; i++) begin
            int gap;
            gap = stray ? 1 : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                ctl_wr_ack = stray && !we;
                ctl_rd_ack = stray && we;
                #1;
                if (c0_wr_ack || c0_rd_ack || c1_wr_ack || c1_rd_ack) n_bad++;
                if ((we ? ctl_wr_req : ctl_rd_req) !== 1'b1) req_ok = 1'b0;
                if (c0_done || c1_done) n_bad++;
                tick();
            end
            ctl_wr_ack = we;
            ctl_rd_ack = !we;
            c0_wdata = 16'($urandom);
            c1_wdata = 16'($urandom);
            #1;
            if (we ? (p == 1 ? c1_wr_ack : c0_wr_ack) : (p == 1 ? c1_rd_ack : c0_rd_ack)) n_fwd++;
            if (we ? (c0_rd_ack || c1_rd_ack) : (c0_wr_ack || c1_wr_ack)) n_bad++;
            if (p == 1 ? (c0_wr_ack || c0_rd_ack) : (c1_wr_ack || c1_rd_ack)) n_bad++;
            if (we && ctl_wdata !== (p == 1 ? c1_wdata : c0_wdata)) n_bad++;
            if ((we ? ctl_wr_req : ctl_rd_req) !== 1'b1) req_ok = 1'b0;
            if (ctl_wr_req && ctl_rd_req) req_ok = 1'b0;
            if (c0_done || c1_done) n_bad++;
            tick();
        end
        ctl_wr_ack = 1'b0;
        ctl_rd_ack = 1'b0;
        #1;
        if (ctl_wr_req || ctl_rd_req) req_ok = 1'b0;
        if (p == 1 ? c1_done : c0_done) n_done++;
        if (p == 1 ? c0_done : c1_done) n_bad++;
        tick();
        if (p == 1 ? c1_done : c0_done) n_done++;
        if (p == 1 ? c1_gnt : c0_gnt) n_bad++;
        model_last = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; init_end = 0;
        c0_req = 0; c0_we = 0; c0_addr = 0; c0_len = 0; c0_wdata = 0;
        c1_req = 0; c1_we = 0; c1_addr = 0; c1_len = 0; c1_wdata = 0;
        ctl_wr_ack = 0; ctl_rd_ack = 0; ctl_rdata = 0;
        tick();
        n_checks++;
        if ({c0_gnt, c1_gnt, ctl_wr_req, ctl_rd_req, c0_done, c1_done} !== 6'b0 ||
            ctl_addr !== 24'h0 || ctl_len !== 10'h0 || ctl_wdata !== 16'h0)
            $display("FAIL reset_outputs: gnt=%b%b req=%b%b addr=%h len=%0d, required all 0",
                     c1_gnt, c0_gnt, ctl_wr_req, ctl_rd_req, ctl_addr, ctl_len);
        else n_pass++;
        rst = 1'b0;
        model_last = 1;
        tick();
    endtask

    task automatic test_init_gate();
        int bad = 0, n_fwd, n_bad, n_done;
        bit req_ok;
        logic [23:0] a;
        logic [9:0] l;
        a = 24'($urandom); l = 10'($urandom_range(1, 8));
        c0_req = 1; c0_we = 1; c0_addr = a; c0_len = l;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c0_gnt || ctl_wr_req || ctl_rd_req) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL init_gate: %0d cycles with grant/req, required 0", bad);
        else n_pass++;
        init_end = 1;
        tick();
        n_checks++;
        if (c0_gnt !== 1'b1 || ctl_wr_req !== 1'b1 || ctl_addr !== a || ctl_len !== l)
            $display("FAIL init_grant: gnt=%b wr_req=%b addr=%h len=%0d, required 1 1 %h %0d",
                     c0_gnt, ctl_wr_req, ctl_addr, ctl_len, a, l);
        else n_pass++;
        c0_req = 0;
        serve_burst(0, 1'b1, int'(l), 1'b0, n_fwd, n_bad, n_done, req_ok);
        n_checks++;
        if (n_fwd != int'(l) || n_bad != 0 || n_done != 1 || !req_ok)
            $display("FAIL init_burst: fwd=%0d bad=%0d done=%0d req_ok=%b, required %0d 0 1 1",
                     n_fwd, n_bad, n_done, req_ok, l);
        else n_pass++;
    endtask

    task automatic test_max_burst();
        int port, n_fwd, n_bad, n_done;
        bit to, req_ok;
        c0_req = 1; c0_we = 1; c0_addr = 24'h0; c0_len = 10'd256;
        wait_grant(port, to);
        n_checks++;
        if (to || port != 0 || ctl_len !== 10'd256 || ctl_wr_req !== 1'b1)
            $display("FAIL max_grant: port=%0d len=%0d wr_req=%b, required 0 256 1",
                     port, ctl_len, ctl_wr_req);
        else n_pass++;
        c0_req = 0;
        serve_burst(0, 1'b1, 256, 1'b0, n_fwd, n_bad, n_done, req_ok);
        n_checks++;
        if (n_fwd != 256 || n_bad != 0 || n_done != 1 || !req_ok)
            $display("FAIL max_burst: fwd=%0d bad=%0d done=%0d req_ok=%b, required 256 0 1 1",
                     n_fwd, n_bad, n_done, req_ok);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int port, exp_p, n_fwd, n_bad, n_done;
        bit to, req_ok;
        apply_reset();
        c0_we = 0; c1_we = 1; c0_len = 10'd3; c1_len = 10'd2;
        c0_req = 1; c1_req = 1;
        for (int r = 0; r < 3; r++) begin
            exp_p = model_pick(c0_req, c1_req, model_last);
            wait_grant(port, to);
            n_checks++;
            if (to || port != exp_p)
                $display("FAIL rr_grant_%0d: port=%0d, required %0d", r, port, exp_p);
            else n_pass++;
            if (port == 1) c1_req = 0; else c0_req = 0;
            serve_burst(exp_p, exp_p == 1, exp_p == 1 ? 2 : 3, 1'b0, n_fwd, n_bad, n_done, req_ok);
            n_checks++;
            if (n_fwd != (exp_p == 1 ? 2 : 3) || n_bad != 0 || n_done != 1 || !req_ok)
                $display("FAIL rr_burst_%0d: fwd=%0d bad=%0d done=%0d req_ok=%b",
                         r, n_fwd, n_bad, n_done, req_ok);
            else n_pass++;
            if (r == 1) begin
                c0_req = 1; c1_req = 1;
            end
        end
        c0_req = 0; c1_req = 0;
    endtask

    task automatic test_stray_ack();
        int port, n_fwd, n_bad, n_done;
        bit to, req_ok;
        c1_req = 1; c1_we = 0; c1_addr = 24'h000100; c1_len = 10'd4;
        wait_grant(port, to);
        n_checks++;
        if (to || port != 1 || ctl_rd_req !== 1'b1 || ctl_wr_req !== 1'b0 || ctl_addr !== 24'h000100)
            $display("FAIL stray_grant: port=%0d rd=%b wr=%b addr=%h, required 1 1 0 000100",
                     port, ctl_rd_req, ctl_wr_req, ctl_addr);
        else n_pass++;
        c1_req = 0;
        c1_addr = 24'hABCDEF; c1_len = 10'd9;
        serve_burst(1, 1'b0, 4, 1'b1, n_fwd, n_bad, n_done, req_ok);
        n_checks++;
        if (n_fwd != 4 || n_bad != 0 || n_done != 1 || !req_ok)
            $display("FAIL stray_burst: fwd=%0d bad=%0d done=%0d req_ok=%b, required 4 0 1 1",
                     n_fwd, n_bad, n_done, req_ok);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int port, n_fwd, n_bad, n_done;
        bit to, req_ok;
        c0_req = 1; c0_we = 1; c0_addr = 24'h123456; c0_len = 10'd256;
        wait_grant(port, to);
        c0_req = 0;
        for (int i = 0; i < 99; i++) begin
            ctl_wr_ack = 1;
            tick();
        end
        ctl_wr_ack = 1;
        rst = 1;
        #1;
        n_checks++;
        if (to || {c0_gnt, c1_gnt, ctl_wr_req, ctl_rd_req, c0_wr_ack, c1_wr_ack, c0_done, c1_done} !== 8'b0 ||
            ctl_addr !== 24'h0 || ctl_len !== 10'h0 || ctl_wdata !== 16'h0)
            $display("FAIL reset_mid_burst: gnt=%b%b req=%b%b ack=%b addr=%h, required all 0",
                     c1_gnt, c0_gnt, ctl_wr_req, ctl_rd_req, c0_wr_ack, ctl_addr);
        else n_pass++;
        ctl_wr_ack = 0;
        tick();
        rst = 0;
        model_last = 1;
        c0_req = 1; c1_req = 1; c1_we = 1; c1_len = 10'd2; c0_len = 10'd2;
        wait_grant(port, to);
        n_checks++;
        if (to || port != model_pick(1'b1, 1'b1, model_last))
            $display("FAIL reset_regrant: port=%0d, required 0", port);
        else n_pass++;
        c0_req = 0; c1_req = 0;
        serve_burst(port, 1'b1, 2, 1'b0, n_fwd, n_bad, n_done, req_ok);
        n_checks++;
        if (n_fwd != 2 || n_bad != 0 || n_done != 1 || !req_ok)
            $display("FAIL reset_regrant_burst: fwd=%0d bad=%0d done=%0d", n_fwd, n_bad, n_done);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        logic [2:0] seen_gnt, seen_done;
        bit req_seen = 0;
        c0_req = 1; c0_we = 1; c0_len = 10'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) c0_req = 0;
            seen_gnt[i]  = c0_gnt;
            seen_done[i] = c0_done;
            if (ctl_wr_req || ctl_rd_req) req_seen = 1;
        end
        n_checks++;
        if (seen_gnt !== 3'b011 || seen_done !== 3'b010 || req_seen)
            $display("FAIL zero_len: gnt=%b done=%b req_seen=%b, required 011 010 0",
                     seen_gnt, seen_done, req_seen);
        else n_pass++;
        model_last = 0;
    endtask

    task automatic test_random_traffic();
        int port, exp_p, n_fwd, n_bad, n_done, l;
        bit to, req_ok, we;
        logic [23:0] a;
        for (int it = 0; it < 20; it++) begin
            int pat;
            pat = $urandom_range(1, 3);
            c0_req = pat[0]; c1_req = pat[1];
            c0_we = 1'($urandom); c1_we = 1'($urandom);
            c0_addr = 24'($urandom); c1_addr = 24'($urandom);
            c0_len = 10'($urandom_range(1, 16)); c1_len = 10'($urandom_range(1, 16));
            exp_p = model_pick(c0_req, c1_req, model_last);
            we = exp_p == 1 ? c1_we : c0_we;
            a  = exp_p == 1 ? c1_addr : c0_addr;
            l  = int'(exp_p == 1 ? c1_len : c0_len);
            wait_grant(port, to);
            n_checks++;
            if (to || port != exp_p || ctl_addr !== a || ctl_len !== 10'(l) ||
                ctl_wr_req !== we || ctl_rd_req !== !we)
                $display("FAIL rand_grant_%0d: port=%0d addr=%h len=%0d wr=%b rd=%b, required %0d %h %0d %b %b",
                         it, port, ctl_addr, ctl_len, ctl_wr_req, ctl_rd_req, exp_p, a, l, we, !we);
            else n_pass++;
            c0_req = 0; c1_req = 0;
            c0_len = 10'($urandom_range(1, 16)); c1_len = 10'($urandom_range(1, 16));
            serve_burst(exp_p, we, l, 1'b0, n_fwd, n_bad, n_done, req_ok);
            n_checks++;
            if (n_fwd != l || n_bad != 0 || n_done != 1 || !req_ok)
                $display("FAIL rand_burst_%0d: fwd=%0d bad=%0d done=%0d req_ok=%b, required %0d 0 1 1",
                         it, n_fwd, n_bad, n_done, req_ok, l);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_max_burst();
        test_round_robin();
        test_stray_ack();
        test_reset_mid_burst();
        test_zero_len();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
